// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with prescaler, synchronous load and wrap/saturate mode.
// Latency: Q and Wrap update one clock after the tick/Load edge. No backpressure: tick is advisory.
module mod_updown_counter #(
  parameter int WIDTH    = 10,
  parameter int MODULUS  = 1024,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap,
  output logic             AtLimit
);

  localparam int               PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);

  generate
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
      $error("mod_updown_counter: illegal MODULUS/WIDTH/PRESCALE combination");
    end
  endgenerate

  logic [PW-1:0]    p, p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             tick, at_top, at_bot;

  always_comb begin
    at_top   = (Q == QMAX);
    at_bot   = (Q == '0);
    tick     = En && (p == PMAX);
    AtLimit  = Up ? at_top : at_bot;
    p_nxt    = p;
    q_nxt    = Q;
    wrap_nxt = 1'b0;

    if (Load) begin
      // Load wins over a coincident tick and restarts the prescaler phase.
      p_nxt = '0;
      q_nxt = (D > QMAX) ? QMAX : D;
    end else begin
      if (En) p_nxt = (p == PMAX) ? '0 : p + PW'(1);
      if (tick) begin
        if (Up) begin
          if (at_top) begin
            wrap_nxt = 1'b1;
            if (SATURATE == 0) q_nxt = '0;
          end else begin
            q_nxt = Q + WIDTH'(1);
          end
        end else begin
          if (at_bot) begin
            wrap_nxt = 1'b1;
            if (SATURATE == 0) q_nxt = QMAX;
          end else begin
            q_nxt = Q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Q    <= '0;
      Wrap <= 1'b0;
      p    <= '0;
    end else begin
      Q    <= q_nxt;
      Wrap <= wrap_nxt;
      p    <= p_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: wrap mode (a), saturate mode (b) and prescale-by-3 (c) instances side by side.
module tb_mod_updown_counter;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       a_rn, a_en, a_up, a_ld, a_w, a_al;
  logic [3:0] a_d, a_q;
  logic       b_rn, b_en, b_up, b_ld, b_w, b_al;
  logic [3:0] b_d, b_q;
  logic       c_rn, c_en, c_up, c_ld, c_w, c_al;
  logic [3:0] c_d, c_q;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
    .Clock(clk), .Resetn(a_rn), .En(a_en), .Up(a_up), .Load(a_ld), .D(a_d),
    .Q(a_q), .Wrap(a_w), .AtLimit(a_al));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
    .Clock(clk), .Resetn(b_rn), .En(b_en), .Up(b_up), .Load(b_ld), .D(b_d),
    .Q(b_q), .Wrap(b_w), .AtLimit(b_al));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_c (
    .Clock(clk), .Resetn(c_rn), .En(c_en), .Up(c_up), .Load(c_ld), .D(c_d),
    .Q(c_q), .Wrap(c_w), .AtLimit(c_al));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int q, input int w, input int al);
    check({tag, ".q"}, 32'(a_q), q);
    check({tag, ".wrap"}, 32'(a_w), w);
    check({tag, ".atlimit"}, 32'(a_al), al);
  endtask

  task automatic chk_b(input string tag, input int q, input int w, input int al);
    check({tag, ".q"}, 32'(b_q), q);
    check({tag, ".wrap"}, 32'(b_w), w);
    check({tag, ".atlimit"}, 32'(b_al), al);
  endtask

  typedef struct packed {
    logic       en;
    logic       ld;
    logic [3:0] d;
    logic [3:0] q;
  } cvec_t;

  // Prescale-by-3 schedule: freeze mid-period, load on a tick cycle, load mid-period.
  cvec_t cv [25] = '{
    '{1'b1, 1'b0, 4'd0, 4'd0}, '{1'b1, 1'b0, 4'd0, 4'd0}, '{1'b1, 1'b0, 4'd0, 4'd1},
    '{1'b1, 1'b0, 4'd0, 4'd1}, '{1'b1, 1'b0, 4'd0, 4'd1},
    '{1'b0, 1'b0, 4'd0, 4'd1}, '{1'b0, 1'b0, 4'd0, 4'd1}, '{1'b0, 1'b0, 4'd0, 4'd1},
    '{1'b0, 1'b0, 4'd0, 4'd1}, '{1'b0, 1'b0, 4'd0, 4'd1},
    '{1'b1, 1'b0, 4'd0, 4'd2}, '{1'b1, 1'b0, 4'd0, 4'd2}, '{1'b1, 1'b0, 4'd0, 4'd2},
    '{1'b1, 1'b0, 4'd0, 4'd3}, '{1'b1, 1'b0, 4'd0, 4'd3}, '{1'b1, 1'b0, 4'd0, 4'd3},
    '{1'b1, 1'b1, 4'd5, 4'd5},
    '{1'b1, 1'b0, 4'd0, 4'd5}, '{1'b1, 1'b0, 4'd0, 4'd5}, '{1'b1, 1'b0, 4'd0, 4'd6},
    '{1'b1, 1'b0, 4'd0, 4'd6},
    '{1'b1, 1'b1, 4'd2, 4'd2},
    '{1'b1, 1'b0, 4'd0, 4'd2}, '{1'b1, 1'b0, 4'd0, 4'd2}, '{1'b1, 1'b0, 4'd0, 4'd3}
  };

  int e2_q [3] = '{9, 8, 7};
  int e2_w [3] = '{1, 0, 0};
  int eb_w [4] = '{0, 1, 1, 1};

  initial begin
    a_rn = 1'b0; a_en = 1'b0; a_up = 1'b1; a_ld = 1'b0; a_d = 4'd0;
    b_rn = 1'b0; b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_d = 4'd0;
    c_rn = 1'b0; c_en = 1'b0; c_up = 1'b1; c_ld = 1'b0; c_d = 4'd0;
    tick_clk();
    tick_clk();

    chk_a("rst_a", 0, 0, 0);
    chk_b("rst_b", 0, 0, 0);
    check("rst_c.q", 32'(c_q), 0);

    // Wrap-mode count up through the top of the range.
    a_rn = 1'b1; a_en = 1'b1; a_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick_clk();
      chk_a($sformatf("up%0d", i), i % 10, (i % 10 == 0) ? 1 : 0, (i % 10 == 9) ? 1 : 0);
    end

    // Down from 0 wraps to 9.
    a_en = 1'b0; a_ld = 1'b1; a_d = 4'd0; a_up = 1'b0;
    tick_clk();
    chk_a("ld0", 0, 0, 1);
    a_ld = 1'b0; a_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      chk_a($sformatf("dn%0d", i), e2_q[i], e2_w[i], 0);
    end

    // Clamped load, then load coinciding with a tick.
    a_en = 1'b0; a_ld = 1'b1; a_d = 4'd12;
    tick_clk();
    chk_a("ld_clamp", 9, 0, 0);
    a_up = 1'b1;
    #1;
    check("atlimit_dir", 32'(a_al), 1);
    a_en = 1'b1; a_ld = 1'b1; a_d = 4'd5;
    tick_clk();
    chk_a("ld_tick", 5, 0, 0);

    // Reset beats load and enable, and clears a pending Wrap.
    a_d = 4'd9;
    tick_clk();
    a_ld = 1'b0;
    tick_clk();
    chk_a("pre_rst", 0, 1, 0);
    a_rn = 1'b0; a_ld = 1'b1; a_d = 4'd7;
    tick_clk();
    chk_a("mid_rst", 0, 0, 0);
    a_rn = 1'b1; a_ld = 1'b0;
    tick_clk();
    chk_a("post_rst", 1, 0, 0);

    // Saturate mode, both directions.
    b_rn = 1'b1; b_ld = 1'b1; b_d = 4'd8;
    tick_clk();
    chk_b("sat_ld8", 8, 0, 0);
    b_ld = 1'b0; b_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      chk_b($sformatf("sat_up%0d", i), 9, eb_w[i], 1);
    end
    b_ld = 1'b1; b_d = 4'd1;
    tick_clk();
    chk_b("sat_ld1", 1, 0, 0);
    b_ld = 1'b0; b_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      chk_b($sformatf("sat_dn%0d", i), 0, eb_w[i], 1);
    end

    // Prescaler schedule.
    c_rn = 1'b1; c_up = 1'b1;
    for (int i = 0; i < 25; i++) begin
      c_en = cv[i].en;
      c_ld = cv[i].ld;
      c_d  = cv[i].d;
      tick_clk();
      check($sformatf("pre%0d.q", i), 32'(c_q), 32'(cv[i].q));
      check($sformatf("pre%0d.wrap", i), 32'(c_w), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
